// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter owning the select of a shared 4:1 mux.
//
// Parameters
//   W         data width of i0..i3 and y
//   MAX_HOLD  max consecutive grant cycles under contention (2..255),
//             only honoured when ARB_MAXHOLD_EN is defined
//
// Ports
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   req[3:0] request per requester k
//   i0..i3   mux data inputs, ik belongs to requester k
//   grant    registered one-hot grant, zero when idle
//   s1, s0   registered select {s1,s0} = owner index (holds last owner when idle)
//   busy     registered, high exactly when grant is non-zero
//   y        combinational: selected input while busy, else 0
//
// Build option
//   ARB_MAXHOLD_EN  enables the hold counter that forces rotation after
//                   MAX_HOLD cycles when another requester is waiting
module mux4_rr_arbiter #(
    parameter int unsigned W        = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [3:0]   grant,
    output logic         s1,
    output logic         s0,
    output logic         busy,
    output logic [W-1:0] y
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    // Elaboration-time range check of the hold limit.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mux4_rr_arbiter: MAX_HOLD must be within 2..255");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } st_t;

    st_t              st, st_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic             busy_nxt;
    logic [NREQ-1:0]  others;
    logic             do_take;
    logic [IDX_W-1:0] pick;

`ifdef ARB_MAXHOLD_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hold_cnt, hold_nxt;
`endif

    // First set bit of v searched from p+1 upward, wrapping back to p.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] p,
                                                 input logic [NREQ-1:0]  v);
        logic [IDX_W-1:0] idx;
        rr_pick = p;
        for (int k = NREQ; k >= 1; k--) begin
            idx = p + IDX_W'(k);
            if (v[idx]) rr_pick = idx;
        end
    endfunction

    // Requests from everyone except the current owner.
    assign others = req & ~NREQ'(4'b0001 << owner);

    // State register (all registered outputs live here).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            owner    <= '0;
            last     <= IDX_W'(3);
            grant    <= '0;
            s1       <= 1'b0;
            s0       <= 1'b0;
            busy     <= 1'b0;
`ifdef ARB_MAXHOLD_EN
            hold_cnt <= '0;
`endif
        end else begin
            st       <= st_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            grant    <= grant_nxt;
            {s1, s0} <= sel_nxt;
            busy     <= busy_nxt;
`ifdef ARB_MAXHOLD_EN
            hold_cnt <= hold_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        last_nxt  = last;
        grant_nxt = grant;
        sel_nxt   = {s1, s0};
        busy_nxt  = busy;
        do_take   = 1'b0;
        pick      = '0;
`ifdef ARB_MAXHOLD_EN
        hold_nxt  = hold_cnt;
`endif

        unique case (st)
            ST_IDLE: begin
                if (|req) begin
                    do_take = 1'b1;
                    pick    = rr_pick(last, req);
                end
            end
            ST_GRANT: begin
                if (!req[owner]) begin
                    // Release: hand over directly, or go idle if nobody waits.
                    if (|others) begin
                        do_take = 1'b1;
                        pick    = rr_pick(owner, others);
                    end else begin
                        st_nxt    = ST_IDLE;
                        grant_nxt = '0;
                        busy_nxt  = 1'b0;
`ifdef ARB_MAXHOLD_EN
                        hold_nxt  = '0;
`endif
                    end
                end
`ifdef ARB_MAXHOLD_EN
                else if (hold_cnt >= HOLD_MAX) begin
                    // Limit reached: rotate if contended, otherwise saturate.
                    if (|others) begin
                        do_take = 1'b1;
                        pick    = rr_pick(owner, others);
                    end
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            default: ;
        endcase

        if (do_take) begin
            st_nxt    = ST_GRANT;
            owner_nxt = pick;
            last_nxt  = pick;
            grant_nxt = NREQ'(4'b0001 << pick);
            sel_nxt   = pick;
            busy_nxt  = 1'b1;
`ifdef ARB_MAXHOLD_EN
            hold_nxt  = 8'd1;
`endif
        end
    end

    // Output mux: data passes straight through from the selected input.
    always_comb begin
        y = '0;
        if (busy) begin
            unique case ({s1, s0})
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = i3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a round-robin reference model.
module tb_mux4_rr_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned MH = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] i0, i1, i2, i3;
    logic [3:0]   grant;
    logic         s1, s0;
    logic         busy;
    logic [W-1:0] y;

    int total = 0;
    int bad   = 0;

    // Reference model state: who holds the mux, whom we served last.
    bit           m_busy;
    int           m_sel;
    int           m_last;
    int           m_hold;
    logic [W-1:0] din [4];

    mux4_rr_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .grant (grant),
        .s1    (s1),
        .s0    (s0),
        .busy  (busy),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr(input int p, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic rn);
        logic [3:0] oth;
        if (!rn) begin
            m_busy = 0; m_sel = 0; m_last = 3; m_hold = 0;
        end else if (!m_busy) begin
            if (r != 0) begin
                m_sel = rr(m_last, r); m_last = m_sel; m_busy = 1; m_hold = 1;
            end
        end else begin
            oth = r;
            oth[m_sel] = 1'b0;
            if (!r[m_sel]) begin
                if (oth != 0) begin
                    m_sel = rr(m_sel, oth); m_last = m_sel; m_hold = 1;
                end else begin
                    m_busy = 0; m_hold = 0;
                end
            end else begin
`ifdef ARB_MAXHOLD_EN
                if (m_hold >= int'(MH)) begin
                    if (oth != 0) begin
                        m_sel = rr(m_sel, oth); m_last = m_sel; m_hold = 1;
                    end
                end else begin
                    m_hold++;
                end
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0]   eg;
        logic [W-1:0] ey;
        eg = m_busy ? 4'(1 << m_sel) : 4'b0000;
        ey = m_busy ? din[m_sel] : '0;
        chk("grant", 8'(grant), 8'(eg));
        chk("sel",   8'({s1, s0}), 8'(m_sel));
        chk("busy",  8'(busy), 8'(m_busy));
        chk("y",     8'(y), 8'(ey));
    endtask

    // Apply one cycle of stimulus, advance model, check #1 after the edge.
    task automatic step(input logic [3:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        for (int k = 0; k < 4; k++) din[k] = W'($urandom);
        i0 = din[0]; i1 = din[1]; i2 = din[2]; i3 = din[3];
        @(posedge clk);
        model_update(r, rn);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] eh;
        req = '0; rst_n = 1'b0; i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        m_busy = 0; m_sel = 0; m_last = 3; m_hold = 0;

        // Reset dominates all-requesting input.
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0);
            chk("rst_grant", 8'(grant), 8'h00);
            chk("rst_busy",  8'(busy),  8'h00);
            chk("rst_y",     8'(y),     8'h00);
        end
        step(4'b1111, 1'b1);
        chk("first_grant", 8'(grant), 8'h01);
        chk("first_sel",   8'({s1, s0}), 8'h00);

        // Single requester, then release to idle.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(4'b0100, 1'b1);
            chk("single_grant", 8'(grant), 8'h04);
            chk("single_sel",   8'({s1, s0}), 8'h02);
        end
        step(4'b0000, 1'b1);
        chk("single_rel_grant", 8'(grant), 8'h00);
        chk("single_rel_busy",  8'(busy),  8'h00);
        chk("single_rel_y",     8'(y),     8'h00);
        chk("single_rel_sel",   8'({s1, s0}), 8'h02);

        // Rotation with two-cycle tenures and no idle gap.
        do_reset();
        step(4'b1111, 1'b1); chk("rot0", 8'(grant), 8'h01);
        step(4'b1111, 1'b1); chk("rot0h", 8'(grant), 8'h01);
        step(4'b1110, 1'b1); chk("rot1", 8'(grant), 8'h02);
        step(4'b1111, 1'b1); chk("rot1h", 8'(grant), 8'h02);
        step(4'b1101, 1'b1); chk("rot2", 8'(grant), 8'h04);
        step(4'b1111, 1'b1); chk("rot2h", 8'(grant), 8'h04);
        step(4'b1011, 1'b1); chk("rot3", 8'(grant), 8'h08);
        step(4'b1111, 1'b1); chk("rot3h", 8'(grant), 8'h08);
        step(4'b0111, 1'b1); chk("rot4", 8'(grant), 8'h01);

        // Pointer skip: after owner 1, requester 3 precedes 0.
        do_reset();
        step(4'b0010, 1'b1); chk("skip_own1", 8'(grant), 8'h02);
        step(4'b1001, 1'b1); chk("skip_next", 8'(grant), 8'h08);

        // Constant contention between 0 and 1.
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            step(4'b0011, 1'b1);
`ifdef ARB_MAXHOLD_EN
            eh = (((c - 1) / int'(MH)) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            eh = 4'b0001;
`endif
            chk("hold_grant", 8'(grant), 8'(eh));
        end

        // Reset in the middle of a grant.
        do_reset();
        step(4'b0100, 1'b1); chk("mid_own2", 8'(grant), 8'h04);
        step(4'b0101, 1'b0); chk("mid_rst", 8'(grant), 8'h00);
        step(4'b0101, 1'b1); chk("mid_after", 8'(grant), 8'h01);

        // Random traffic; owners tend to hold so the hold limit gets exercised.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r = 4'($urandom);
            if (m_busy && ($urandom_range(0, 7) != 0)) r[m_sel] = 1'b1;
            step(r, ($urandom_range(0, 59) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
